// File: rtl/pdp8_iobus_if.sv
// PDP-8 I/O bus bundle: CPU IOT path, per-device responses, DMA channels and memory port.
// The bus module takes the slave modport; the surrounding system drives the master side.
interface pdp8_iobus_if #(
  parameter int unsigned NDEV = 4,
  parameter int unsigned NDMA = 2,
  parameter int unsigned IW   = 4
);
  logic                 iot;
  logic [5:0]           io_select;
  logic [NDEV*6-1:0]    dev_code;
  logic [NDEV*12-1:0]   dev_data_out;
  logic [NDEV-1:0]      dev_data_avail;
  logic [NDEV-1:0]      dev_skip;
  logic [NDEV-1:0]      dev_clear_ac;
  logic [NDEV-1:0]      dev_interrupt;
  logic [NDEV-1:0]      dev_selected;
  logic [11:0]          io_data_out;
  logic                 io_data_avail;
  logic                 io_skip;
  logic                 io_clear_ac;
  logic                 io_interrupt;
  logic [IW-1:0]        io_int_dev;
  logic [NDMA-1:0]      dma_read_req;
  logic [NDMA-1:0]      dma_write_req;
  logic [NDMA*15-1:0]   dma_ma;
  logic [NDMA*12-1:0]   dma_wdata;
  logic [NDMA-1:0]      dma_done;
  logic [11:0]          dma_rdata;
  logic                 io_ram_read_req;
  logic                 io_ram_write_req;
  logic [14:0]          io_ram_ma;
  logic [11:0]          io_ram_out;
  logic                 io_ram_done;
  logic [11:0]          io_ram_in;

  modport master (
    output iot, io_select, dev_code, dev_data_out, dev_data_avail, dev_skip, dev_clear_ac,
           dev_interrupt, dma_read_req, dma_write_req, dma_ma, dma_wdata, io_ram_done, io_ram_in,
    input  dev_selected, io_data_out, io_data_avail, io_skip, io_clear_ac, io_interrupt,
           io_int_dev, dma_done, dma_rdata, io_ram_read_req, io_ram_write_req, io_ram_ma,
           io_ram_out
  );

  modport slave (
    input  iot, io_select, dev_code, dev_data_out, dev_data_avail, dev_skip, dev_clear_ac,
           dev_interrupt, dma_read_req, dma_write_req, dma_ma, dma_wdata, io_ram_done, io_ram_in,
    output dev_selected, io_data_out, io_data_avail, io_skip, io_clear_ac, io_interrupt,
           io_int_dev, dma_done, dma_rdata, io_ram_read_req, io_ram_write_req, io_ram_ma,
           io_ram_out
  );
endinterface

// File: rtl/pdp8_iobus.sv
// PDP-8 I/O bus: IOT device select and response mux, interrupt collection, and a
// round-robin data-break arbiter in front of a single memory port.
module pdp8_iobus #(
  parameter int unsigned NDEV = 4,
  parameter int unsigned NDMA = 2,
  parameter int unsigned IW   = 4
) (
  input logic         clk,
  input logic         reset,
  pdp8_iobus_if.slave bus
);

  localparam int unsigned PW = (NDMA > 1) ? $clog2(NDMA) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_grant;
  logic [14:0]       r_ma;
  logic [11:0]       r_wdata;
  logic              r_write;
  logic              r_read_req;
  logic              r_write_req;
  logic [NDMA-1:0]   r_done;
  logic [11:0]       r_rdata;
  logic [NDEV-1:0]   r_int;

  logic [NDEV-1:0]   w_sel;
  logic              w_hit;
  logic [11:0]       w_data;
  logic              w_avail;
  logic              w_skip;
  logic              w_clear;
  logic [IW-1:0]     w_int_dev;
  logic [NDMA-1:0]   w_req;
  logic              w_any;
  logic [PW-1:0]     w_pick;
  logic [PW-1:0]     w_next_ptr;

  // Lowest-index match wins so duplicate device codes never produce two selects.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (!w_hit && bus.iot && (bus.io_select == bus.dev_code[6*i +: 6])) begin
        w_sel[i] = 1'b1;
        w_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    w_data  = '0;
    w_avail = 1'b0;
    w_skip  = 1'b0;
    w_clear = 1'b0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (w_sel[i]) begin
        w_data  = w_data | bus.dev_data_out[12*i +: 12];
        w_avail = w_avail | bus.dev_data_avail[i];
        w_skip  = w_skip | bus.dev_skip[i];
        w_clear = w_clear | bus.dev_clear_ac[i];
      end
    end
  end

  always_comb begin
    w_int_dev = '0;
    for (int i = int'(NDEV) - 1; i >= 0; i--) begin
      if (r_int[i]) begin
        w_int_dev = IW'(i);
      end
    end
  end

  // A channel seeing its done pulse this cycle is masked so it is not re-granted before it
  // has had the chance to drop its request.
  assign w_req = (bus.dma_read_req | bus.dma_write_req) & ~r_done;

  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < int'(NDMA); k++) begin
      if (!w_any && w_req[(int'(r_ptr) + k) % int'(NDMA)]) begin
        w_any  = 1'b1;
        w_pick = PW'((int'(r_ptr) + k) % int'(NDMA));
      end
    end
  end

  assign w_next_ptr = (r_grant == PW'(NDMA - 1)) ? '0 : r_grant + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_ma        <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_read_req  <= 1'b0;
      r_write_req <= 1'b0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_int       <= '0;
    end else begin
      r_int  <= bus.dev_interrupt;
      r_done <= '0;
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_ma    <= bus.dma_ma[15*int'(w_pick) +: 15];
            r_wdata <= bus.dma_wdata[12*int'(w_pick) +: 12];
            // Write takes priority when a channel raises both requests.
            r_write <= bus.dma_write_req[w_pick];
            r_state <= StIssue;
          end
        end
        StIssue: begin
          r_read_req  <= ~r_write;
          r_write_req <= r_write;
          r_state     <= StWait;
        end
        StWait: begin
          if (bus.io_ram_done) begin
            r_read_req      <= 1'b0;
            r_write_req     <= 1'b0;
            r_done[r_grant] <= 1'b1;
            if (!r_write) begin
              r_rdata <= bus.io_ram_in;
            end
            r_ptr   <= w_next_ptr;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.dev_selected     = w_sel;
  assign bus.io_data_out      = w_data;
  assign bus.io_data_avail    = w_avail;
  assign bus.io_skip          = w_skip;
  assign bus.io_clear_ac      = w_clear;
  assign bus.io_interrupt     = |r_int;
  assign bus.io_int_dev       = w_int_dev;
  assign bus.dma_done         = r_done;
  assign bus.dma_rdata        = r_rdata;
  assign bus.io_ram_read_req  = r_read_req;
  assign bus.io_ram_write_req = r_write_req;
  assign bus.io_ram_ma        = r_ma;
  assign bus.io_ram_out       = r_wdata;

endmodule

// File: tb/tb_pdp8_iobus.sv
// Bench for pdp8_iobus: transaction-level model with per-cycle compare, a memory responder
// and directed scenarios with literal expectations.
module tb_pdp8_iobus;
  localparam int unsigned NDEV = 4;
  localparam int unsigned NDMA = 2;
  localparam int unsigned IW   = 4;

  logic clk = 1'b0;
  logic reset;
  logic stray_req;
  int   checks = 0;
  int   errors = 0;
  int   mem_cnt;

  always #5 clk = ~clk;

  pdp8_iobus_if #(.NDEV(NDEV), .NDMA(NDMA), .IW(IW)) bus ();

  pdp8_iobus #(.NDEV(NDEV), .NDMA(NDMA), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Device model: first port whose code matches, or -1.
  function automatic int sel_idx();
    for (int i = 0; i < int'(NDEV); i++) begin
      if (bus.iot && bus.io_select == bus.dev_code[6*i +: 6]) return i;
    end
    return -1;
  endfunction

  function automatic int lowest_bit(input logic [NDEV-1:0] v);
    for (int i = 0; i < int'(NDEV); i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int chan_of(input logic [14:0] ma);
    for (int c = 0; c < int'(NDMA); c++) if (bus.dma_ma[15*c +: 15] == ma) return c;
    return 0;
  endfunction

  function automatic logic [11:0] mem_data(input logic [14:0] ma);
    if (ma == 15'o00200) return 12'o1234;
    return ma[11:0] ^ 12'o5555;
  endfunction

  logic [NDEV-1:0] m_int;
  logic [NDMA-1:0] m_done;
  logic [11:0]     m_rdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_int   <= '0;
      m_done  <= '0;
      m_rdata <= '0;
    end else begin
      m_int  <= bus.dev_interrupt;
      m_done <= '0;
      if (bus.io_ram_done && (bus.io_ram_read_req || bus.io_ram_write_req)) begin
        m_done <= NDMA'(1) << chan_of(bus.io_ram_ma);
        if (bus.io_ram_read_req) m_rdata <= bus.io_ram_in;
      end
    end
  end

  always @(negedge clk) begin
    int s;
    s = sel_idx();
    chk("dev_selected", bus.dev_selected, (s < 0) ? 0 : (1 << s));
    chk("io_data_out", bus.io_data_out, (s < 0) ? 0 : bus.dev_data_out[12*s +: 12]);
    chk("io_data_avail", bus.io_data_avail, (s < 0) ? 0 : bus.dev_data_avail[s]);
    chk("io_skip", bus.io_skip, (s < 0) ? 0 : bus.dev_skip[s]);
    chk("io_clear_ac", bus.io_clear_ac, (s < 0) ? 0 : bus.dev_clear_ac[s]);
    chk("io_interrupt", bus.io_interrupt, (m_int != 0));
    chk("io_int_dev", bus.io_int_dev, lowest_bit(m_int));
    chk("dma_done", bus.dma_done, m_done);
    chk("dma_rdata", bus.dma_rdata, m_rdata);
    chk("ram_req_excl", bus.io_ram_read_req && bus.io_ram_write_req, 0);
  end

  // Memory: completes a request two cycles after it appears; can also emit a stray done.
  initial begin
    bus.io_ram_done = 1'b0;
    bus.io_ram_in   = '0;
    mem_cnt         = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bus.io_ram_done = 1'b0;
        mem_cnt         = 0;
      end else if (bus.io_ram_done) begin
        bus.io_ram_done = 1'b0;
      end else if (bus.io_ram_read_req || bus.io_ram_write_req) begin
        mem_cnt++;
        if (mem_cnt > 2) begin
          bus.io_ram_done = 1'b1;
          bus.io_ram_in   = mem_data(bus.io_ram_ma);
          mem_cnt         = 0;
        end
      end else if (stray_req) begin
        bus.io_ram_done = 1'b1;
        bus.io_ram_in   = 12'o7070;
      end else begin
        mem_cnt = 0;
      end
    end
  end

  task automatic wait_req(input string name);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.io_ram_read_req || bus.io_ram_write_req) return;
    end
    chk({name, "_req_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.dma_done != 0) return;
    end
    chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    stray_req          = 1'b0;
    bus.iot            = 1'b0;
    bus.io_select      = '0;
    bus.dev_code       = {6'o61, 6'o60, 6'o04, 6'o03};
    bus.dev_data_out   = '0;
    bus.dev_data_avail = '0;
    bus.dev_skip       = '0;
    bus.dev_clear_ac   = '0;
    bus.dev_interrupt  = '0;
    bus.dma_read_req   = '0;
    bus.dma_write_req  = '0;
    bus.dma_ma         = '0;
    bus.dma_wdata      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_req", bus.io_ram_read_req, 0);
    chk("rst_write_req", bus.io_ram_write_req, 0);
    chk("rst_dma_done", bus.dma_done, 0);
    chk("rst_rdata", bus.dma_rdata, 0);
    chk("rst_int_dev", bus.io_int_dev, 0);
    chk("rst_ram_ma", bus.io_ram_ma, 0);
    reset = 1'b0;

    // Device select and response mux.
    @(posedge clk);
    #1;
    bus.iot                 = 1'b1;
    bus.io_select           = 6'o04;
    bus.dev_skip            = 4'b0010;
    bus.dev_data_out[11:0]  = 12'o1111;
    bus.dev_data_out[23:12] = 12'o7777;
    bus.dev_data_avail      = 4'b0100;
    #1;
    chk("s1_sel", bus.dev_selected, 4'b0010);
    chk("s1_skip", bus.io_skip, 1);
    chk("s1_data", bus.io_data_out, 12'o7777);
    chk("s1_avail", bus.io_data_avail, 0);
    bus.dev_code[23:18] = 6'o04;
    #1 chk("s1_dup_sel", bus.dev_selected, 4'b0010);
    bus.dev_code[23:18] = 6'o61;
    bus.io_select       = 6'o05;
    #1;
    chk("s1_nosel", bus.dev_selected, 0);
    chk("s1_nodata", bus.io_data_out, 0);
    chk("s1_noskip", bus.io_skip, 0);
    bus.io_select = 6'o04;
    bus.iot       = 1'b0;
    #1 chk("s1_noiot", bus.dev_selected, 0);

    // Interrupts: one-cycle latency, lowest index reported.
    @(posedge clk);
    #1 bus.dev_interrupt = 4'b1100;
    @(negedge clk);
    chk("s2_latency", bus.io_interrupt, 0);
    @(posedge clk);
    #1;
    chk("s2_int", bus.io_interrupt, 1);
    chk("s2_dev2", bus.io_int_dev, 2);
    bus.dev_interrupt = 4'b1000;
    @(posedge clk);
    #1 chk("s2_dev3", bus.io_int_dev, 3);
    bus.dev_interrupt = 4'b0000;
    @(posedge clk);
    #1 chk("s2_clear", bus.io_interrupt, 0);

    // Channel 0 read.
    bus.dma_ma[14:0]   = 15'o00200;
    bus.dma_ma[29:15]  = 15'o00300;
    bus.dma_read_req   = 2'b01;
    wait_req("s3");
    chk("s3_rd", bus.io_ram_read_req, 1);
    chk("s3_wr", bus.io_ram_write_req, 0);
    chk("s3_ma", bus.io_ram_ma, 15'o00200);
    wait_done("s3");
    chk("s3_done", bus.dma_done, 2'b01);
    chk("s3_rdata", bus.dma_rdata, 12'o1234);
    @(posedge clk);
    #1;
    bus.dma_read_req = '0;
    chk("s3_pulse", bus.dma_done, 0);

    // Channel 1 read+write resolves to a write; read data held.
    bus.dma_wdata[23:12] = 12'o5252;
    bus.dma_read_req     = 2'b10;
    bus.dma_write_req    = 2'b10;
    wait_req("s6");
    chk("s6_wr", bus.io_ram_write_req, 1);
    chk("s6_rd", bus.io_ram_read_req, 0);
    chk("s6_out", bus.io_ram_out, 12'o5252);
    chk("s6_ma", bus.io_ram_ma, 15'o00300);
    wait_done("s6");
    chk("s6_done", bus.dma_done, 2'b10);
    chk("s6_hold", bus.dma_rdata, 12'o1234);
    @(posedge clk);
    #1;
    bus.dma_read_req  = '0;
    bus.dma_write_req = '0;

    // Stray memory done while idle is ignored.
    @(posedge clk);
    #2 stray_req = 1'b1;
    @(posedge clk);
    #3 stray_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("s7_nodone", bus.dma_done, 0);
      chk("s7_noreq", bus.io_ram_read_req || bus.io_ram_write_req, 0);
    end

    // Round-robin between two continuously requesting channels.
    do_reset();
    bus.dma_ma[14:0] = 15'o00100;
    bus.dma_read_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_req("s4");
      chk("s4_grant", chan_of(bus.io_ram_ma), k % 2);
      wait_done("s4");
      chk("s4_done", bus.dma_done, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    @(posedge clk);
    #1 bus.dma_read_req = '0;
    repeat (10) @(posedge clk);

    // Reset during WAIT abandons the transfer; afterwards channel 0 wins.
    #1 bus.dma_read_req = 2'b10;
    wait_req("s5");
    chk("s5_pre_ma", bus.io_ram_ma, 15'o00300);
    #1;
    reset            = 1'b1;
    bus.dma_read_req = 2'b11;
    #1;
    chk("s5_rd", bus.io_ram_read_req, 0);
    chk("s5_wr", bus.io_ram_write_req, 0);
    chk("s5_done", bus.dma_done, 0);
    chk("s5_ma", bus.io_ram_ma, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_req("s5b");
    chk("s5_grant0", bus.io_ram_ma, 15'o00100);
    wait_done("s5b");
    chk("s5_done0", bus.dma_done, 2'b01);
    @(posedge clk);
    #1 bus.dma_read_req = '0;
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
